cache_arbiter: RTL
==================

Name: cache_arbiter

Overview:
- Responder for the memory-side ports of the I-cache and D-cache. Each port carries 256-bit line requests using the mem_read / mem_write / mem_resp handshake.
- Arbitrates between the two caches and initiates exactly one transaction at a time on the single physical-memory (cacheline adaptor) port.
- Routes the memory response and read line back to the granted cache.
- Sits between the L1 caches and the cacheline adaptor in the mp4 top level.

Parameters:
- LINE_W, 256, cache line width in bits.
- STARVE_MAX, 4, consecutive data grants allowed while an instruction request is waiting; after this count the instruction port is forced.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- i_mem_read  in  1  I-cache line read request
- i_mem_address  in  32  I-cache line address
- i_mem_rdata  out  LINE_W  line returned to I-cache
- i_mem_resp  out  1  I-cache transaction complete
- d_mem_read  in  1  D-cache line read request
- d_mem_write  in  1  D-cache line writeback request
- d_mem_address  in  32  D-cache line address
- d_mem_wdata  in  LINE_W  D-cache writeback line
- d_mem_rdata  out  LINE_W  line returned to D-cache
- d_mem_resp  out  1  D-cache transaction complete
- pmem_read  out  1  read request to adaptor
- pmem_write  out  1  write request to adaptor
- pmem_address  out  32  latched request address
- pmem_wdata  out  LINE_W  latched writeback line
- pmem_rdata  in  LINE_W  line from adaptor
- pmem_resp  in  1  adaptor transaction complete (one-cycle pulse)
- arb_sel  out  1  current/last grant: 0 = inst, 1 = data (arbdatamux_sel_t encoding)

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- Reset values:
  - state = IDLE, arb_sel = 0, starve counter = 0.
  - pmem_read, pmem_write, i_mem_resp, d_mem_resp = 0.
  - pmem_address = 0, pmem_wdata = 0; both rdata outputs = 0.
- IDLE, grant decision (combinational on inputs, taken at the clock edge):
  - D request only -> SERVE_D.
  - I request only -> SERVE_I.
  - Both pending -> SERVE_D, unless starve counter == STARVE_MAX, in which case SERVE_I.
  - No request -> stay in IDLE.
- On grant:
  - Latch address; for a D write, also latch wdata.
  - Latch op type. If d_mem_read and d_mem_write are both high, treat as a write.
  - Set arb_sel to the granted port.
- pmem_read / pmem_write:
  - Asserted from the first cycle in SERVE_x. There is no combinational path from request inputs to pmem outputs; grant-to-pmem latency is 1 cycle.
  - Held constant until pmem_resp is seen.
  - Latched values are unaffected by requester input changes during service.
- Response cycle (SERVE_x with pmem_resp = 1):
  - Granted port's x_mem_resp = 1 in the same cycle (combinational forward).
  - x_mem_rdata = pmem_rdata in that cycle.
  - The non-granted port's resp stays 0 throughout.
  - Next state is RELEASE.
- rdata outputs: registered copies of the last returned line, so they remain stable after resp. Both ports see their own last line.
- RELEASE:
  - Lasts exactly 1 cycle; pmem_read/pmem_write = 0, no grant.
  - Next state is IDLE.
  - Minimum gap between transactions is therefore 2 cycles (RELEASE + IDLE decision).
- Starve counter:
  - Increments on a D grant made while i_mem_read is high, saturating at STARVE_MAX.
  - Clears on any I grant.
  - Clears on a D grant made while i_mem_read is low.
- Requester drops its request mid-service: the transaction still completes on memory; resp is still pulsed and is ignored by the requester.
- pmem_resp in IDLE or RELEASE: ignored, no resp forwarded.
- rst asserted mid-transaction: return to IDLE next edge with all outputs at reset values. The adaptor must tolerate request withdrawal.

Test Plan:
- I read only, addr 0x0000_0040; adaptor responds 5 cycles after pmem_read rises with line 0xAA..AA.
  - pmem_read high at grant+1 with pmem_address 0x40.
  - i_mem_resp pulse for 1 cycle with i_mem_rdata 0xAA..AA.
  - d_mem_resp stays 0; pmem_read low in the RELEASE cycle.
- D write, addr 0x100, wdata 0x55..55, and I read, addr 0x200, raised in the same IDLE cycle.
  - Grants D first: arb_sel = 1, pmem_write = 1, pmem_wdata 0x55..55.
  - After resp and RELEASE, grants I: arb_sel = 0, pmem_address 0x200.
- D requests back-to-back continuously while an I request is held pending.
  - Exactly 4 D grants, then an I grant.
  - Counter clears; D is served next.
- Change d_mem_address from 0x300 to 0x999 during SERVE_D.
  - pmem_address stays 0x300 until resp.
- Pulse rst during SERVE_I.
  - Next cycle state is IDLE; pmem_read = 0, resp = 0.
  - A late pmem_resp is not forwarded.
- Spurious pmem_resp while in IDLE with no requests.
  - i_mem_resp and d_mem_resp both stay 0; state stays IDLE.

Source files
------------

// File: rtl/cache_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// cache_arbiter_if : L1 cache / arbiter / cacheline-adaptor handshake bundle
// Revision 1.0
// ============================================================================
interface cache_arbiter_if #(
  parameter int LINE_W = 256
);
  logic              i_mem_read;
  logic [31:0]       i_mem_address;
  logic [LINE_W-1:0] i_mem_rdata;
  logic              i_mem_resp;

  logic              d_mem_read;
  logic              d_mem_write;
  logic [31:0]       d_mem_address;
  logic [LINE_W-1:0] d_mem_wdata;
  logic [LINE_W-1:0] d_mem_rdata;
  logic              d_mem_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  logic              arb_sel;

  // Arbiter view: takes cache requests and adaptor responses
  modport slave (
    input  i_mem_read, i_mem_address,
    input  d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
    input  pmem_rdata, pmem_resp,
    output i_mem_rdata, i_mem_resp, d_mem_rdata, d_mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata, arb_sel
  );

  // Environment view: caches plus adaptor
  modport master (
    output i_mem_read, i_mem_address,
    output d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
    output pmem_rdata, pmem_resp,
    input  i_mem_rdata, i_mem_resp, d_mem_rdata, d_mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, arb_sel
  );
endinterface
`default_nettype wire

// File: rtl/cache_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// cache_arbiter : I/D cache arbiter onto a single cacheline-adaptor port
// Revision 1.0
// ============================================================================
module cache_arbiter #(
  parameter int LINE_W     = 256,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  cache_arbiter_if.slave bus
);
  localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  starve_cnt;
  logic              pmem_read_q;
  logic              pmem_write_q;
  logic              sel_q;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] i_line;
  logic [LINE_W-1:0] d_line;

  logic d_req;
  logic grant_d;
  logic grant_i;
  logic i_resp;
  logic d_resp;

  // Data wins ties unless the instruction side has waited STARVE_MAX grants
  always_comb begin
    d_req   = bus.d_mem_read | bus.d_mem_write;
    grant_d = d_req & ~(bus.i_mem_read & (starve_cnt == STARVE_LIM));
    grant_i = bus.i_mem_read & ~grant_d;
    i_resp  = (state == SERVE_I) & bus.pmem_resp;
    d_resp  = (state == SERVE_D) & bus.pmem_resp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      sel_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_line       <= '0;
      d_line       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state        <= SERVE_D;
            sel_q        <= 1'b1;
            addr_q       <= bus.d_mem_address;
            // A simultaneous read+write is treated as a writeback
            pmem_write_q <= bus.d_mem_write;
            pmem_read_q  <= ~bus.d_mem_write;
            if (bus.d_mem_write) begin
              wdata_q <= bus.d_mem_wdata;
            end
            if (!bus.i_mem_read) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else if (grant_i) begin
            state        <= SERVE_I;
            sel_q        <= 1'b0;
            addr_q       <= bus.i_mem_address;
            pmem_read_q  <= 1'b1;
            pmem_write_q <= 1'b0;
            starve_cnt   <= '0;
          end
        end
        SERVE_I: begin
          if (bus.pmem_resp) begin
            state        <= RELEASE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            i_line       <= bus.pmem_rdata;
          end
        end
        SERVE_D: begin
          if (bus.pmem_resp) begin
            state        <= RELEASE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            d_line       <= bus.pmem_rdata;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.arb_sel      = sel_q;
  assign bus.i_mem_resp   = i_resp;
  assign bus.d_mem_resp   = d_resp;
  // Forward the line in the response cycle, then hold the registered copy
  assign bus.i_mem_rdata  = i_resp ? bus.pmem_rdata : i_line;
  assign bus.d_mem_rdata  = d_resp ? bus.pmem_rdata : d_line;
endmodule
`default_nettype wire
